// File: rtl/conv_deinterleaver.sv
// Convolutional deinterleaver (I branches, M-byte cells) with HUNT/LOCK sync tracking and fill gating.
// Latency 1 cycle; no backpressure, so every in_valid byte is consumed and idle cycles freeze all state.
module conv_deinterleaver #(
  parameter int I   = 12,
  parameter int M   = 17,
  parameter int PKT = 204
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] in,
  input  logic       in_valid,
  input  logic       in_sync,
  output logic [7:0] out,
  output logic       out_valid,
  output logic       out_sync,
  output logic       sync_err
);

  localparam int FILL = (I - 1) * M * I;
  localparam int BW   = $clog2(I);
  localparam int FW   = $clog2(FILL + 1);
  localparam int PW   = $clog2(PKT);

  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  logic [0:0]    state;
  logic [BW-1:0] branch;
  logic [FW-1:0] fill;
  logic [PW-1:0] pkt;

  logic          enter;
  logic          resync;
  logic          proc;
  logic [BW-1:0] eff_branch;
  logic [FW-1:0] eff_fill;
  logic [PW-1:0] eff_pkt;
  logic [7:0]    rd [I];

  // A sync byte either opens LOCK or, when it lands off branch 0, realigns the commutator.
  always_comb begin
    enter      = (state == HUNT) && in_valid && in_sync;
    resync     = (state == LOCK) && in_valid && in_sync && (branch != '0);
    proc       = in_valid && ((state == LOCK) || in_sync);
    eff_branch = branch;
    eff_fill   = fill;
    eff_pkt    = pkt;
    if (enter || resync) begin
      eff_branch = '0;
      eff_fill   = '0;
      eff_pkt    = '0;
    end
  end

  assign rd[I-1] = in;

  for (genvar j = 0; j < I - 1; j++) begin : g_branch
    localparam int DEPTH = (I - 1 - j) * M;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp;
    logic          hit;

    assign hit   = proc && (eff_branch == BW'(j));
    assign rd[j] = mem[wp];

    // Contents survive reset on purpose; the fill counter hides whatever is left behind.
    always_ff @(posedge Clk) begin
      if (!Reset && hit) begin
        mem[wp] <= in;
      end
    end

    always_ff @(posedge Clk) begin
      if (Reset) begin
        wp <= '0;
      end else if (hit) begin
        wp <= (wp == AW'(DEPTH - 1)) ? '0 : wp + AW'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= HUNT;
      branch    <= '0;
      fill      <= '0;
      pkt       <= '0;
      out       <= 8'h00;
      out_valid <= 1'b0;
      out_sync  <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_sync  <= 1'b0;
      sync_err  <= resync;
      if (proc) begin
        state     <= LOCK;
        branch    <= (eff_branch == BW'(I - 1)) ? '0 : eff_branch + BW'(1);
        fill      <= (eff_fill == FW'(FILL)) ? eff_fill : eff_fill + FW'(1);
        pkt       <= (eff_pkt == PW'(PKT - 1)) ? '0 : eff_pkt + PW'(1);
        out       <= rd[eff_branch];
        out_valid <= (eff_fill == FW'(FILL));
        out_sync  <= (eff_fill == FW'(FILL)) && (eff_pkt == '0);
      end
    end
  end

endmodule

// File: tb/tb_conv_deinterleaver.sv
// Bench for conv_deinterleaver: hand-written vector table plus interleaved random streams checked
// against a history-indexed deinterleaver model.
module tb_conv_deinterleaver;

  localparam int I    = 12;
  localparam int M    = 17;
  localparam int PKT  = 204;
  localparam int FILL = (I - 1) * M * I;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] din;
  logic       in_valid;
  logic       in_sync;
  logic [7:0] out;
  logic       out_valid;
  logic       out_sync;
  logic       sync_err;

  conv_deinterleaver #(.I(I), .M(M), .PKT(PKT)) dut (
    .Clk(Clk), .Reset(Reset), .in(din), .in_valid(in_valid), .in_sync(in_sync),
    .out(out), .out_valid(out_valid), .out_sync(out_sync), .sync_err(sync_err)
  );

  always #5 Clk = ~Clk;

  int         tests = 0;
  int         fails = 0;
  int         vcount = 0;
  bit         locked = 1'b0;
  logic [7:0] acc[$];
  logic [7:0] orig[$];

  typedef struct {
    logic       r, v, s;
    logic [7:0] d;
    logic       ev, es, ee;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: once locked, accepted byte n on branch j=n%I leaves as the byte accepted (I-1-j)*M*I
  // bytes earlier, and only after FILL bytes have been accepted since the last (re)alignment.
  task automatic cycle(input logic r, input logic v, input logic s, input logic [7:0] d);
    logic       ev, es, ee, chk_out;
    logic [7:0] eo;
    int         n, j;
    ev = 0; es = 0; ee = 0; eo = 8'h00; chk_out = 0;
    if (r) begin
      locked = 0;
      acc.delete();
      chk_out = 1;
    end else if (v) begin
      if (s && (!locked || (acc.size() % I) != 0)) begin
        ee = locked;
        locked = 1;
        acc.delete();
      end
      if (locked) begin
        n = acc.size();
        acc.push_back(d);
        j = n % I;
        if (n >= FILL) begin
          ev = 1;
          eo = acc[n - (I - 1 - j) * M * I];
          es = ((n % PKT) == 0);
          chk_out = 1;
        end
      end
    end
    Reset = r; in_valid = v; in_sync = s; din = d;
    @(posedge Clk);
    #1;
    if (out_valid === 1'b1) vcount++;
    check("out_valid", 32'(out_valid), 32'(ev));
    check("out_sync", 32'(out_sync), 32'(es));
    check("sync_err", 32'(sync_err), 32'(ee));
    if (chk_out) check("out", 32'(out), 32'(eo));
  endtask

  task automatic do_reset(input int cycles);
    repeat (cycles) cycle(1'b1, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
  endtask

  task automatic fill_orig(input int npk);
    logic [7:0] base;
    base = 8'($urandom);
    orig.delete();
    for (int k = 0; k < npk * PKT; k++)
      orig.push_back(((k % PKT) == 0) ? 8'h47 : 8'(base + 8'(k)));
  endtask

  // Transmit-side interleaver: branch j delays by j*M visits, starting from zeroed cells.
  task automatic send_stream(input int nbytes, input bit toggle);
    int         j, src;
    logic [7:0] b;
    logic       s;
    for (int n = 0; n < nbytes; n++) begin
      j   = n % I;
      src = n - j * M * I;
      b   = (src >= 0) ? orig[src] : 8'h00;
      s   = (src >= 0) && ((src % PKT) == 0);
      cycle(1'b0, 1'b1, s, b);
      if (toggle) cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
    end
  endtask

  initial begin
    vec_t tbl[12];
    Reset = 1'b1; in_valid = 1'b0; in_sync = 1'b0; din = 8'h00;

    tbl[0]  = '{1'b1, 1'b1, 1'b1, 8'h47, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'h12, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 8'hB8, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 8'h47, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 8'h47, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 8'h47, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 8'hB8, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      Reset = tbl[i].r; in_valid = tbl[i].v; in_sync = tbl[i].s; din = tbl[i].d;
      @(posedge Clk);
      #1;
      check("tbl_out_valid", 32'(out_valid), 32'(tbl[i].ev));
      check("tbl_out_sync", 32'(out_sync), 32'(tbl[i].es));
      check("tbl_sync_err", 32'(sync_err), 32'(tbl[i].ee));
      if (tbl[i].r) check("tbl_reset_out", 32'(out), 32'h0);
    end

    // Back-to-back stream: ten packets come out after the fill latency.
    do_reset(2);
    fill_orig(21);
    vcount = 0;
    send_stream(21 * PKT, 1'b0);
    check("plain_valid_count", 32'(vcount), 32'(10 * PKT));

    // Junk before the first sync must be dropped in HUNT.
    do_reset(2);
    repeat (50) cycle(1'b0, 1'b1, 1'b0, 8'hFF);
    fill_orig(21);
    vcount = 0;
    send_stream(21 * PKT, 1'b0);
    check("junk_valid_count", 32'(vcount), 32'(10 * PKT));

    // Gapped input: idle cycles between every byte.
    do_reset(2);
    fill_orig(21);
    vcount = 0;
    send_stream(21 * PKT, 1'b1);
    check("gap_valid_count", 32'(vcount), 32'(10 * PKT));

    // Sync lands on branch 5 after 3005 bytes: resync and a fresh fill period.
    do_reset(2);
    fill_orig(15);
    send_stream(3005, 1'b0);
    fill_orig(13);
    vcount = 0;
    send_stream(13 * PKT, 1'b0);
    check("resync_valid_count", 32'(vcount), 32'(13 * PKT - FILL));

    // Reset in place of accepted byte 3000, then ignored non-sync bytes, then relock.
    do_reset(2);
    fill_orig(15);
    send_stream(2999, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 8'($urandom));
    repeat (20) cycle(1'b0, 1'b1, 1'b0, 8'($urandom));
    fill_orig(13);
    vcount = 0;
    send_stream(13 * PKT, 1'b0);
    check("relock_valid_count", 32'(vcount), 32'(13 * PKT - FILL));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
